// File: rtl/music_play_ctrl.sv
// Playback sequencer for the two-song note ROM: song select, play/pause/stop, note stepping
// every BEAT_DIV cycles, and an optional silent gap before the end-of-song action.

module music_play_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int SONG0_START = 0,
  parameter int SONG0_END   = 138,
  parameter int SONG1_START = 139,
  parameter int SONG1_END   = 335,
  parameter int BEAT_DIV    = 4,
  parameter int GAP_BEATS   = 2,
  parameter int AUTO_NEXT   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BTN_PLAY,
  input  logic              BTN_STOP,
  input  logic              BTN_NEXT,
  input  logic              BTN_PREV,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic [3:0]        STATE,
  output logic              PLAYING,
  output logic              MUTE,
  output logic              SONG_END
);

  localparam int BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int GW = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;

  localparam logic [BW-1:0]     BEAT_LAST = BW'(BEAT_DIV - 1);
  localparam logic [GW-1:0]     GAP_LAST  = GW'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);
  localparam logic [ADDR_W-1:0] S0_START  = ADDR_W'(SONG0_START);
  localparam logic [ADDR_W-1:0] S0_END    = ADDR_W'(SONG0_END);
  localparam logic [ADDR_W-1:0] S1_START  = ADDR_W'(SONG1_START);
  localparam logic [ADDR_W-1:0] S1_END    = ADDR_W'(SONG1_END);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_GAP   = 2'd3
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic              song_q, song_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              song_end_q, song_end_d;
  logic [3:0]        code_q, code_d;
  logic              playing_q, playing_d;
  logic              mute_q, mute_d;

  logic              nav;
  logic              run;
  logic              step;
  logic              end_act;

  function automatic logic [ADDR_W-1:0] song_start(input logic song);
    return song ? S1_START : S0_START;
  endfunction

  function automatic logic [ADDR_W-1:0] song_last(input logic song);
    return song ? S1_END : S0_END;
  endfunction

  always_comb begin
    fsm_d      = fsm_q;
    song_d     = song_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    song_end_d = 1'b0;
    end_act    = 1'b0;

    // NEXT and PREV together cancel each other out
    nav  = BTN_NEXT ^ BTN_PREV;
    run  = (fsm_q == ST_PLAY) || (fsm_q == ST_GAP);
    step = run && (beat_q == BEAT_LAST);

    if (run) begin
      beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BW'(1);
    end
    if (fsm_q == ST_IDLE) begin
      beat_d = '0;
      gap_d  = '0;
    end

    if (BTN_STOP) begin
      fsm_d  = ST_IDLE;
      addr_d = song_start(song_q);
      beat_d = '0;
      gap_d  = '0;
    end else if (nav) begin
      song_d = ~song_q;
      addr_d = song_start(~song_q);
      beat_d = '0;
      gap_d  = '0;
      if (fsm_q == ST_GAP) begin
        fsm_d = ST_PLAY;
      end
    end else if (BTN_PLAY && (fsm_q != ST_GAP)) begin
      case (fsm_q)
        ST_IDLE:  begin
          fsm_d  = ST_PLAY;
          beat_d = '0;
        end
        ST_PLAY:  fsm_d = ST_PAUSE;
        ST_PAUSE: fsm_d = ST_PLAY;
        default:  fsm_d = fsm_q;
      endcase
    end else if (step) begin
      if (fsm_q == ST_PLAY) begin
        if (addr_q != song_last(song_q)) begin
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          song_end_d = 1'b1;
          if (GAP_BEATS > 0) begin
            fsm_d = ST_GAP;
            gap_d = '0;
          end else begin
            end_act = 1'b1;
          end
        end
      end else begin
        if (gap_q == GAP_LAST) begin
          end_act = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
    end

    // End of song (after any gap): chain into the other song or park at the start
    if (end_act) begin
      beat_d = '0;
      gap_d  = '0;
      if (AUTO_NEXT != 0) begin
        song_d = ~song_q;
        addr_d = song_start(~song_q);
        fsm_d  = ST_PLAY;
      end else begin
        addr_d = song_start(song_q);
        fsm_d  = ST_IDLE;
      end
    end

    code_d    = song_d ? 4'd2 : 4'd1;
    playing_d = (fsm_d == ST_PLAY) || (fsm_d == ST_GAP);
    mute_d    = (fsm_d != ST_PLAY);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fsm_q      <= ST_IDLE;
      song_q     <= 1'b0;
      addr_q     <= S0_START;
      beat_q     <= '0;
      gap_q      <= '0;
      song_end_q <= 1'b0;
      code_q     <= 4'd1;
      playing_q  <= 1'b0;
      mute_q     <= 1'b1;
    end else begin
      fsm_q      <= fsm_d;
      song_q     <= song_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      song_end_q <= song_end_d;
      code_q     <= code_d;
      playing_q  <= playing_d;
      mute_q     <= mute_d;
    end
  end

  assign ROM_ADDR = addr_q;
  assign STATE    = code_q;
  assign PLAYING  = playing_q;
  assign MUTE     = mute_q;
  assign SONG_END = song_end_q;

endmodule

// File: tb/tb_music_play_ctrl.sv
// Scoreboard bench for music_play_ctrl: u_a uses defaults, u_b has AUTO_NEXT=0.
// Stimulus queues expected outputs tagged with the clock edge they must appear after.

module tb_music_play_ctrl;

  localparam logic [3:0] B_PLAY = 4'b1000;
  localparam logic [3:0] B_STOP = 4'b0100;
  localparam logic [3:0] B_NEXT = 4'b0010;
  localparam logic [3:0] B_PREV = 4'b0001;

  logic       clk;
  logic       rst_n;
  logic       a_play, a_stop, a_next, a_prev;
  logic       b_play, b_stop, b_next, b_prev;
  logic [9:0] a_addr, b_addr;
  logic [3:0] a_state, b_state;
  logic       a_playing, a_mute, a_send;
  logic       b_playing, b_mute, b_send;

  typedef struct {
    int         cyc;
    int         dut;
    logic [9:0] addr;
    logic [3:0] st;
    logic       pl;
    logic       mu;
    logic       se;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   b_done   = 1'b0;

  music_play_ctrl u_a (
    .CLK(clk), .RST_N(rst_n),
    .BTN_PLAY(a_play), .BTN_STOP(a_stop), .BTN_NEXT(a_next), .BTN_PREV(a_prev),
    .ROM_ADDR(a_addr), .STATE(a_state), .PLAYING(a_playing), .MUTE(a_mute), .SONG_END(a_send)
  );

  music_play_ctrl #(.AUTO_NEXT(0)) u_b (
    .CLK(clk), .RST_N(rst_n),
    .BTN_PLAY(b_play), .BTN_STOP(b_stop), .BTN_NEXT(b_next), .BTN_PREV(b_prev),
    .ROM_ADDR(b_addr), .STATE(b_state), .PLAYING(b_playing), .MUTE(b_mute), .SONG_END(b_send)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_at(input int dut, input int cyc, input int addr, input int st,
                           input bit pl, input bit mu, input bit se, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.dut  = dut;
    e.addr = 10'(addr);
    e.st   = 4'(st);
    e.pl   = pl;
    e.mu   = mu;
    e.se   = se;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic check_one(input exp_t e);
    logic [9:0] addr;
    logic [3:0] st;
    logic       pl, mu, se;
    if (e.dut == 0) {addr, st, pl, mu, se} = {a_addr, a_state, a_playing, a_mute, a_send};
    else            {addr, st, pl, mu, se} = {b_addr, b_state, b_playing, b_mute, b_send};
    n_checks++;
    if (e.cyc != edge_n) begin
      n_errors++;
      $display("FAIL %s: expectation for edge %0d reached monitor at edge %0d", e.name, e.cyc, edge_n);
    end else if ({addr, st, pl, mu, se} !== {e.addr, e.st, e.pl, e.mu, e.se}) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got addr=%0d state=%0d playing=%b mute=%b song_end=%b, expected addr=%0d state=%0d playing=%b mute=%b song_end=%b",
               e.name, edge_n, addr, st, pl, mu, se, e.addr, e.st, e.pl, e.mu, e.se);
    end
  endtask

  // Monitor: counts edges, compares every expectation that is due at this edge
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= edge_n) begin
          check_one(sb[i]);
          sb.delete(i);
        end
      end
    end
  end

  // Drive a one-cycle button pulse on u_a that is sampled at edge e
  task automatic press_a(input int e, input logic [3:0] b);
    while (edge_n < e - 1) @(negedge clk);
    {a_play, a_stop, a_next, a_prev} = b;
    @(negedge clk);
    {a_play, a_stop, a_next, a_prev} = 4'b0000;
  endtask

  initial begin
    int t0, e, f, g;
    rst_n = 1'b0;
    {a_play, a_stop, a_next, a_prev} = 4'b0000;
    expect_at(0, 1, 0, 1, 0, 1, 0, "reset_edge1");
    expect_at(0, 2, 0, 1, 0, 1, 0, "reset_edge2");
    expect_at(1, 2, 0, 1, 0, 1, 0, "reset_b");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Play, pause, resume with beat phase kept
    t0 = edge_n + 1;
    expect_at(0, t0,      0, 1, 1, 0, 0, "play_start");
    expect_at(0, t0 + 3,  0, 1, 1, 0, 0, "before_first_step");
    expect_at(0, t0 + 4,  1, 1, 1, 0, 0, "first_step");
    expect_at(0, t0 + 8,  2, 1, 1, 0, 0, "second_step");
    expect_at(0, t0 + 9,  2, 1, 0, 1, 0, "pause");
    expect_at(0, t0 + 19, 2, 1, 0, 1, 0, "pause_hold");
    expect_at(0, t0 + 20, 2, 1, 1, 0, 0, "resume");
    expect_at(0, t0 + 22, 2, 1, 1, 0, 0, "resume_pre_step");
    expect_at(0, t0 + 23, 3, 1, 1, 0, 0, "resume_phase_step");

    // Song 0 end, gap, auto-advance; then song 1 end wraps to song 0
    e = t0 + 567;
    f = e + 796;
    expect_at(0, e - 1, 138, 1, 1, 0, 0, "song0_last_note");
    expect_at(0, e,     138, 1, 1, 1, 1, "song0_end_pulse");
    expect_at(0, e + 1, 138, 1, 1, 1, 0, "song_end_one_cycle");
    expect_at(0, e + 7, 138, 1, 1, 1, 0, "gap_still_muted");
    expect_at(0, e + 8, 139, 2, 1, 0, 0, "song1_start");
    expect_at(0, f - 1, 335, 2, 1, 0, 0, "song1_last_note");
    expect_at(0, f,     335, 2, 1, 1, 1, "song1_end_pulse");
    expect_at(0, f + 8, 0,   1, 1, 0, 0, "wrap_to_song0");
    expect_at(0, f + 208, 50, 1, 1, 0, 0, "pre_reset_addr50");
    expect_at(0, f + 209, 0,  1, 0, 1, 0, "mid_play_reset");
    expect_at(0, f + 210, 0,  1, 0, 1, 0, "reset_hold");
    expect_at(0, f + 211, 0,  1, 0, 1, 0, "post_reset_idle");
    press_a(t0, B_PLAY);
    press_a(t0 + 9, B_PLAY);
    press_a(t0 + 20, B_PLAY);

    while (edge_n < f + 208) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Button priority and navigation from idle/play
    g = edge_n + 2;
    expect_at(0, g,      139, 2, 0, 1, 0, "prev_in_idle");
    expect_at(0, g + 2,  139, 2, 0, 1, 0, "next_prev_ignored");
    expect_at(0, g + 4,  139, 2, 1, 0, 0, "play_song1");
    expect_at(0, g + 8,  140, 2, 1, 0, 0, "song1_step");
    expect_at(0, g + 10, 139, 2, 0, 1, 0, "stop_over_next");
    expect_at(0, g + 12, 139, 2, 1, 0, 0, "play_with_next_prev");
    expect_at(0, g + 14, 0,   1, 1, 0, 0, "next_over_play");
    expect_at(0, g + 17, 0,   1, 1, 0, 0, "next_beat_restart");
    expect_at(0, g + 18, 1,   1, 1, 0, 0, "next_first_step");
    expect_at(0, g + 20, 0,   1, 0, 1, 0, "stop_rewind");
    press_a(g,      B_PREV);
    press_a(g + 2,  B_NEXT | B_PREV);
    press_a(g + 4,  B_PLAY);
    press_a(g + 10, B_STOP | B_NEXT);
    press_a(g + 12, B_NEXT | B_PREV | B_PLAY);
    press_a(g + 14, B_NEXT | B_PLAY);
    press_a(g + 20, B_STOP);

    repeat (3) @(negedge clk);
    while (!b_done) @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expectations never compared, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // u_b: song 1 runs to its end and parks in IDLE; PLAY during the gap is ignored
  initial begin
    int hb, h;
    {b_play, b_stop, b_next, b_prev} = 4'b0000;
    while (edge_n < 4) @(negedge clk);
    hb = edge_n + 1;
    h  = hb + 789;
    expect_at(1, hb,     139, 2, 0, 1, 0, "b_next_idle");
    expect_at(1, hb + 1, 139, 2, 1, 0, 0, "b_play");
    expect_at(1, h - 1,  335, 2, 1, 0, 0, "b_last_note");
    expect_at(1, h,      335, 2, 1, 1, 1, "b_song_end");
    expect_at(1, h + 2,  335, 2, 1, 1, 0, "b_play_in_gap_ignored");
    expect_at(1, h + 7,  335, 2, 1, 1, 0, "b_gap_hold");
    expect_at(1, h + 8,  139, 2, 0, 1, 0, "b_stop_at_end");
    b_next = 1'b1;
    @(negedge clk);
    b_next = 1'b0;
    b_play = 1'b1;
    @(negedge clk);
    b_play = 1'b0;
    while (edge_n < h + 1) @(negedge clk);
    b_play = 1'b1;
    @(negedge clk);
    b_play = 1'b0;
    while (edge_n < h + 9) @(negedge clk);
    b_done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at edge %0d, %0d expectations pending", edge_n, sb.size());
    $fatal(1);
  end

endmodule
